// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the SAP-2 memory responder.
package mem_responder_pkg;

    // Bit positions inside the CPU control byte; bits 7:4 are reserved.
    localparam int CTRL_MAL = 0;
    localparam int CTRL_MAH = 1;
    localparam int CTRL_WE  = 2;
    localparam int CTRL_RE  = 3;

    // Data returned for a read whose address lies outside the storage.
    localparam logic [7:0] OOR_RDATA = 8'h00;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder pin bundle. The CPU side is the master.
interface mem_responder_if;
    logic [7:0] ctrl_in;
    logic [7:0] bus_in;
    logic [7:0] sram_out;
    logic       rd_valid;
    logic       busy;

    modport master (output ctrl_in, bus_in, input sram_out, rd_valid, busy);
    modport slave  (input ctrl_in, bus_in, output sram_out, rd_valid, busy);
endinterface

// File: rtl/mem_responder_array.sv
// 2^ADDR_W x 8 storage: one synchronous write port plus a registered read.
// A read and a write to the same location on one edge returns the old byte.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_d, rdata_q;

    // Storage write; no reset, contents are defined by the post-reset clear.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data register holds its value between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    // Read register state; samples the pre-edge contents (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= OOR_RDATA;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the SAP-2 external memory pins.
// Clears its storage after reset, then serves MAL/MAH/WE/RE every cycle.
// Optional feature: define MEM_RESPONDER_AUTOINC_EN to post-increment the
// address after each accepted WE/RE (an address load takes priority).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  mif
);

    state_e            state_d, state_q;
    logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;
    logic [15:0]       addr_d, addr_q;
    logic              rd_valid_d, rd_valid_q;
    logic              oor_rd_d, oor_rd_q;

    logic              cmd_mal, cmd_mah, cmd_we, cmd_re;
    logic              addr_oor;
    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [7:0]        arr_wdata, arr_rdata;
    logic              unused_ctrl;

    assign cmd_mal     = mif.ctrl_in[CTRL_MAL];
    assign cmd_mah     = mif.ctrl_in[CTRL_MAH];
    assign cmd_we      = mif.ctrl_in[CTRL_WE];
    assign cmd_re      = mif.ctrl_in[CTRL_RE];
    assign unused_ctrl = ^mif.ctrl_in[7:4];

    // Any address bit above the storage width set means out of range.
    if (ADDR_W < 16) begin : g_oor
        assign addr_oor = |addr_q[15:ADDR_W];
    end else begin : g_full
        assign addr_oor = 1'b0;
    end

    // FSM state, clear pointer and access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            addr_q     <= 16'h0000;
            rd_valid_q <= 1'b0;
            oor_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            oor_rd_q   <= oor_rd_d;
        end
    end

    // Next state: walk every location once, then serve commands.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == '1) state_d = READY;
        end
    end

    // FSM outputs: storage port steering, read strobe and range flag.
    always_comb begin
        arr_we     = 1'b0;
        arr_waddr  = addr_q[ADDR_W-1:0];
        arr_wdata  = mif.bus_in;
        arr_re     = 1'b0;
        rd_valid_d = 1'b0;
        oor_rd_d   = oor_rd_q;
        if (state_q == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = clr_ptr_q;
            arr_wdata = 8'h00;
        end else begin
            arr_we     = cmd_we & ~addr_oor;
            arr_re     = cmd_re & ~addr_oor;
            rd_valid_d = cmd_re;
            if (cmd_re) oor_rd_d = addr_oor;
        end
    end

    // Address register: loads from the bus; WE/RE this edge see the old value.
    always_comb begin
        addr_d = addr_q;
        if (state_q == READY) begin
            if (cmd_mal || cmd_mah) begin
                if (cmd_mal) addr_d[7:0]  = mif.bus_in;
                if (cmd_mah) addr_d[15:8] = mif.bus_in;
            end
`ifdef MEM_RESPONDER_AUTOINC_EN
            else if (cmd_we || cmd_re) begin
                addr_d = addr_q + 16'd1;
            end
`endif
        end
    end

    mem_responder_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (addr_q[ADDR_W-1:0]),
        .rdata (arr_rdata)
    );

    assign mif.sram_out = oor_rd_q ? OOR_RDATA : arr_rdata;
    assign mif.rd_valid = rd_valid_q;
    assign mif.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=8).
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic saw;

    mem_responder_if ifc();

    mem_responder #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one command for one edge, then return #1 after that edge.
    task automatic cyc(input logic [7:0] c, input logic [7:0] b);
        ifc.ctrl_in = c;
        ifc.bus_in  = b;
        @(posedge clk);
        #1;
    endtask

    // Hold a command and count edges until busy drops (bounded).
    task automatic wait_clear(input logic [7:0] c, input logic [7:0] b,
                              output int cnt, output logic seen_rdv);
        cnt = 0;
        seen_rdv = 1'b0;
        ifc.ctrl_in = c;
        ifc.bus_in  = b;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ifc.rd_valid) seen_rdv = 1'b1;
            if (!ifc.busy) break;
        end
    endtask

    initial begin
        ifc.ctrl_in = 8'h00;
        ifc.bus_in  = 8'h00;
        #12;
        chk("rst_busy", ifc.busy, 1);
        chk("rst_sram", ifc.sram_out, 8'h00);
        chk("rst_rdv", ifc.rd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_clear(8'h00, 8'h00, n, saw);
        chk("clear_len", n, 256);
        chk("clear_rdv", saw, 0);

        // read of cleared location 0
        cyc(8'h08, 8'h00);
        chk("rd0_data", ifc.sram_out, 8'h00);
        chk("rd0_vld", ifc.rd_valid, 1);
        cyc(8'h00, 8'h00);
        chk("rd0_pulse", ifc.rd_valid, 0);

        // write then read 0x0012
        cyc(8'h01, 8'h12);
        cyc(8'h02, 8'h00);
        cyc(8'h04, 8'hA5);
        cyc(8'h01, 8'h12);
        cyc(8'h08, 8'h00);
        chk("wr_rd", ifc.sram_out, 8'hA5);
        chk("wr_rd_vld", ifc.rd_valid, 1);
        cyc(8'h00, 8'h00);
        chk("hold", ifc.sram_out, 8'hA5);
        chk("hold_vld", ifc.rd_valid, 0);

        // MAL+MAH together -> 0x4040, out of range: write dropped, read 00
        cyc(8'h03, 8'h40);
        cyc(8'h04, 8'h99);
        cyc(8'h08, 8'h00);
        chk("both_ld_oor", ifc.sram_out, 8'h00);
        chk("both_ld_vld", ifc.rd_valid, 1);

        // simultaneous WE+RE at 0x0040
        cyc(8'h02, 8'h00);
        cyc(8'h01, 8'h40);
        cyc(8'h04, 8'h11);
        cyc(8'h01, 8'h40);
        cyc(8'h0C, 8'h22);
        chk("rbw_old", ifc.sram_out, 8'h11);
        cyc(8'h01, 8'h40);
        cyc(8'h08, 8'h00);
        chk("rbw_new", ifc.sram_out, 8'h22);

        // load in the same cycle as RE: RE uses the old address
        cyc(8'h01, 8'h40);
        cyc(8'h09, 8'h12);
        chk("ld_re_old", ifc.sram_out, 8'h22);
        cyc(8'h08, 8'h00);
        chk("ld_re_new", ifc.sram_out, 8'hA5);

        // out of range 0x0100: write dropped, read 00
        cyc(8'h02, 8'h01);
        cyc(8'h01, 8'h00);
        cyc(8'h04, 8'h55);
        cyc(8'h08, 8'h00);
        chk("oor_rd", ifc.sram_out, 8'h00);
        chk("oor_vld", ifc.rd_valid, 1);
        cyc(8'h02, 8'h00);
        cyc(8'h01, 8'h40);
        cyc(8'h08, 8'h00);
        chk("pre_mem0", ifc.sram_out, 8'h22);
        cyc(8'h01, 8'h00);
        cyc(8'h08, 8'h00);
        chk("oor_mem0", ifc.sram_out, 8'h00);

        // reserved bits only: no read, output holds
        cyc(8'h01, 8'h12);
        cyc(8'h08, 8'h00);
        cyc(8'hF0, 8'h33);
        chk("rsvd_vld", ifc.rd_valid, 0);
        chk("rsvd_hold", ifc.sram_out, 8'hA5);

        // address 0x00FF, two writes back to back
        cyc(8'h01, 8'hFF);
        cyc(8'h04, 8'h01);
        cyc(8'h04, 8'h02);
`ifdef MEM_RESPONDER_AUTOINC_EN
        cyc(8'h08, 8'h00);
        chk("inc_oor", ifc.sram_out, 8'h00);
        chk("inc_oor_vld", ifc.rd_valid, 1);
`endif
        cyc(8'h02, 8'h00);
        cyc(8'h01, 8'hFF);
        cyc(8'h08, 8'h00);
`ifdef MEM_RESPONDER_AUTOINC_EN
        chk("mem_ff", ifc.sram_out, 8'h01);
`else
        chk("mem_ff", ifc.sram_out, 8'h02);
`endif

        // reset, 100 clear cycles with commands, reset again mid-clear
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cyc(8'h0D, 8'h5A);
        chk("mid_busy", ifc.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", ifc.busy, 1);
        chk("rst2_sram", ifc.sram_out, 8'h00);
        chk("rst2_vld", ifc.rd_valid, 0);
        #2;
        rst_n = 1'b1;
        wait_clear(8'h0D, 8'h5A, n, saw);
        chk("clear2_len", n, 256);
        chk("clear2_rdv", saw, 0);

        cyc(8'h08, 8'h00);
        chk("post_addr0", ifc.sram_out, 8'h00);
        chk("post_addr0_vld", ifc.rd_valid, 1);
        cyc(8'h01, 8'h12);
        cyc(8'h04, 8'h7E);
        cyc(8'h01, 8'hFF);
        cyc(8'h08, 8'h00);
        chk("post_ff_clr", ifc.sram_out, 8'h00);
        cyc(8'h01, 8'h12);
        cyc(8'h08, 8'h00);
        chk("post_wr", ifc.sram_out, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
